template_mem_arbiter: RTL and testbench
=======================================

// Module: template_mem_arbiter
// PURPOSE
//  Owns the single-port template RAM that holds the NUM_TEMPLATES trained word windows.
//  Shares the RAM between two requesters at burst granularity:
//   - the training writer, which stores one WORDS x DATA_W word window per slot
//   - the matcher reader, which streams one template per request
//  Sits between the button/training capture path and the wake-word matcher.
//  Tracks which slots hold a complete template.
// PARAMETERS
//  NUM_TEMPLATES  15   template slots; slot ids 0..NUM_TEMPLATES-1
//  WORDS          50   DATA_W-bit bin words per template
//  DATA_W         16   bits per bin word (one bit per channel)
//  ADDR_W         10   RAM address width; must satisfy 2^ADDR_W >= NUM_TEMPLATES*WORDS
// PORTS
//  clk            in   1              system clock
//  rst_n          in   1              asynchronous active-low reset
//  wr_req         in   1              writer requests a burst (level)
//  wr_slot        in   4              target slot, sampled at grant
//  wr_gnt         out  1              writer owns RAM; high from grant through wr_done cycle
//  wr_valid       in   1              wr_data valid
//  wr_data        in   DATA_W         bin word
//  wr_ready       out  1              arbiter accepts wr_data this cycle
//  wr_done        out  1              1-cycle pulse: burst finished or rejected
//  rd_req         in   1              matcher requests a template (level)
//  rd_slot        in   4              source slot, sampled at grant
//  rd_gnt         out  1              reader owns RAM
//  rd_data_valid  out  1              rd_data valid; no backpressure
//  rd_data        out  DATA_W         template word, in order 0..WORDS-1
//  rd_last        out  1              qualifies final word
//  rd_done        out  1              1-cycle pulse, coincident with rd_last or with a reject
//  clear_all      in   1              invalidate all slots
//  slot_valid     out  NUM_TEMPLATES  bit n = slot n holds a complete template
//  busy           out  1              state != IDLE
//  err_slot       out  1              1-cycle pulse: request rejected, slot >= NUM_TEMPLATES
//  mem_en         out  1              RAM enable, registered
//  mem_we         out  1              RAM write enable, registered
//  mem_addr       out  ADDR_W         RAM address, registered
//  mem_wdata      out  DATA_W         RAM write data, registered
//  mem_rdata      in   DATA_W         RAM read data; valid the cycle after mem_en
// BEHAVIOUR
//  Reset: every output is 0; slot_valid=0; state=IDLE; last_grant=READER.
//  FSM: IDLE -> WR_BURST | RD_BURST | IDLE (reject).
//   - WR_BURST -> IDLE on the cycle after the WORDS-th word is accepted.
//   - RD_BURST -> IDLE on the cycle after rd_last.
//  Arbitration happens only in IDLE.
//   - One request pending: that requester wins.
//   - Both pending: the requester not granted last wins (round-robin). The writer wins the first tie after reset.
//   - Grant takes effect on the next cycle. Slot is latched; base = slot*WORDS is registered.
//  Reject: if the winner's slot >= NUM_TEMPLATES, no gnt and no RAM access.
//   - err_slot and that requester's *_done pulse together on the next cycle.
//   - Return to IDLE; last_grant is updated.
//  Write burst:
//   - slot_valid[slot] clears at grant.
//   - wr_ready = WR_BURST && cnt < WORDS.
//   - Handshake in cycle t -> mem_en=mem_we=1, mem_addr=base+cnt, mem_wdata=wr_data in cycle t+1.
//   - wr_valid gaps are allowed.
//   - After the last accepted word: wr_done pulses and slot_valid[slot] sets in the next cycle; wr_gnt drops the cycle after.
//  Read burst:
//   - Issue one read per cycle, mem_we=0, addresses base..base+WORDS-1.
//   - Grant cycle G: first mem_en at G+1, mem_rdata at G+2, rd_data registered and valid at G+3.
//   - rd_last/rd_done at G+WORDS+2; IDLE at G+WORDS+3.
//   - If slot_valid[slot]=0 at grant: the burst still runs with full timing, but rd_data is forced to 0.
//  Deasserting *_req mid-burst does not abort the burst. The requester must drop req by its *_done cycle or it is re-arbitrated.
//  clear_all: clears slot_valid in any state. It wins over a same-cycle set from wr_done. It does not abort a burst.
//  Reset mid-burst: immediate return to reset values. The partial write leaves its slot invalid.
// TESTING
//  1 Write slot 3 with words 0x0001..0x0032, wr_valid continuous
//     -> 50 mem writes at addr 150..199
//     -> wr_done 1 cycle after the last accept; slot_valid=0x0008
//  2 Read slot 3 after test 1 -> first rd_data_valid at G+3, data 0x0001..0x0032; rd_last=rd_done at G+52
//  3 wr_req and rd_req asserted the same cycle from reset
//     -> writer granted first, reader granted in the IDLE cycle after wr_done
//     -> next tie goes to the writer
//  4 rd_req with rd_slot=15 -> no mem_en; err_slot and rd_done pulse once, 1 cycle after the request
//  5 Read never-written slot 7 -> 50 rd_data_valid words, all 0x0000
//  6 rst_n low mid write burst of slot 2 (after 20 words)
//     -> all outputs 0; slot_valid[2]=0
//     -> clear_all coincident with wr_done leaves that slot's bit 0

Source files
------------

// File: rtl/template_mem_arbiter.sv
// Burst-granular arbiter between the training writer and the matcher reader for the
// single-port template RAM; also tracks which template slots hold a complete window.
//   state    | meaning
//   S_IDLE   | no owner; arbitrate, grant or reject the winner
//   S_WR     | writer owns RAM; accept WORDS words, then one wr_done cycle
//   S_RD     | reader owns RAM; issue WORDS reads, wait for rd_last
module template_mem_arbiter #(
    parameter int NUM_TEMPLATES = 15,
    parameter int WORDS         = 50,
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_req_i,
    input  logic [3:0]               wr_slot_i,
    output logic                     wr_gnt_o,
    input  logic                     wr_valid_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     wr_ready_o,
    output logic                     wr_done_o,
    input  logic                     rd_req_i,
    input  logic [3:0]               rd_slot_i,
    output logic                     rd_gnt_o,
    output logic                     rd_data_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_last_o,
    output logic                     rd_done_o,
    input  logic                     clear_all_i,
    output logic [NUM_TEMPLATES-1:0] slot_valid_o,
    output logic                     busy_o,
    output logic                     err_slot_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic [DATA_W-1:0]        mem_rdata_i
);
    localparam int CNT_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [NUM_TEMPLATES-1:0] done_mask_q, done_mask_d;
    logic [NUM_TEMPLATES-1:0] slot_valid_q, slot_valid_d;
    logic                     rd_ok_q, rd_ok_d;
    logic                     last_wr_q, last_wr_d;
    logic                     err_q, err_d, wr_rej_q, wr_rej_d, rd_rej_q, rd_rej_d;
    logic                     mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic                     rd_pend_q, rd_pend_d, last_en_q, last_en_d;
    logic                     last_pend_q, last_pend_d, rd_last_q, rd_last_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]        rd_data_q, rd_data_d;

    logic                     pick_wr, pick_rd, win_bad, arb, grant, reject;
    logic [3:0]               win_slot;
    logic [NUM_TEMPLATES-1:0] win_mask;
    logic                     wr_ready, wr_hs, wr_burst_done, rd_issue;

    // Ties go to whoever was not served last; last_wr_q resets to "reader".
    always_comb begin
        pick_wr  = wr_req_i & (~rd_req_i | ~last_wr_q);
        pick_rd  = rd_req_i & ~pick_wr;
        win_slot = pick_wr ? wr_slot_i : rd_slot_i;
        win_bad  = (int'(win_slot) >= NUM_TEMPLATES);
        arb      = (state_q == S_IDLE) & (pick_wr | pick_rd);
        grant    = arb & ~win_bad;
        reject   = arb & win_bad;
        win_mask = win_bad ? '0 : (NUM_TEMPLATES'(1) << win_slot);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant) state_d = pick_wr ? S_WR : S_RD;
            S_WR:   if (cnt_q == CNT_W'(WORDS)) state_d = S_IDLE;
            S_RD:   if (rd_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_gnt_o      = (state_q == S_WR);
        rd_gnt_o      = (state_q == S_RD);
        busy_o        = (state_q != S_IDLE);
        wr_ready      = (state_q == S_WR) & (cnt_q < CNT_W'(WORDS));
        wr_hs         = wr_ready & wr_valid_i;
        wr_burst_done = (state_q == S_WR) & (cnt_q == CNT_W'(WORDS));
        rd_issue      = (state_q == S_RD) & (cnt_q < CNT_W'(WORDS));
        wr_ready_o    = wr_ready;
        wr_done_o     = wr_burst_done | wr_rej_q;
        rd_done_o     = rd_last_q | rd_rej_q;
    end

    always_comb begin
        cnt_d        = cnt_q;
        base_d       = base_q;
        done_mask_d  = done_mask_q;
        rd_ok_d      = rd_ok_q;
        last_wr_d    = last_wr_q;
        slot_valid_d = slot_valid_q;
        err_d        = reject;
        wr_rej_d     = reject & pick_wr;
        rd_rej_d     = reject & pick_rd;
        if (arb) last_wr_d = pick_wr;
        if (grant) begin
            cnt_d       = '0;
            base_d      = ADDR_W'(win_slot) * ADDR_W'(WORDS);
            done_mask_d = win_mask;
            rd_ok_d     = |(slot_valid_q & win_mask);
            if (pick_wr) slot_valid_d = slot_valid_q & ~win_mask;
        end else if (wr_hs | rd_issue) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (wr_burst_done) slot_valid_d = slot_valid_d | done_mask_q;
        if (clear_all_i) slot_valid_d = '0;

        mem_en_d    = wr_hs | rd_issue;
        mem_we_d    = wr_hs;
        mem_addr_d  = mem_en_d ? base_q + ADDR_W'(cnt_q) : '0;
        mem_wdata_d = wr_hs ? wr_data_i : '0;

        // Read return pipeline: RAM latency one cycle, then the rd_data register.
        rd_pend_d   = mem_en_q & ~mem_we_q;
        last_en_d   = rd_issue & (cnt_q == CNT_W'(WORDS - 1));
        last_pend_d = last_en_q;
        rd_last_d   = last_pend_q;
        rd_valid_d  = rd_pend_q;
        rd_data_d   = (rd_pend_q & rd_ok_q) ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            base_q       <= '0;
            done_mask_q  <= '0;
            slot_valid_q <= '0;
            rd_ok_q      <= 1'b0;
            last_wr_q    <= 1'b0;
            err_q        <= 1'b0;
            wr_rej_q     <= 1'b0;
            rd_rej_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_pend_q    <= 1'b0;
            last_en_q    <= 1'b0;
            last_pend_q  <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            done_mask_q  <= done_mask_d;
            slot_valid_q <= slot_valid_d;
            rd_ok_q      <= rd_ok_d;
            last_wr_q    <= last_wr_d;
            err_q        <= err_d;
            wr_rej_q     <= wr_rej_d;
            rd_rej_q     <= rd_rej_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_pend_q    <= rd_pend_d;
            last_en_q    <= last_en_d;
            last_pend_q  <= last_pend_d;
            rd_last_q    <= rd_last_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign slot_valid_o    = slot_valid_q;
    assign err_slot_o      = err_q;
    assign mem_en_o        = mem_en_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign rd_data_valid_o = rd_valid_q;
    assign rd_data_o       = rd_data_q;
    assign rd_last_o       = rd_last_q;
endmodule

// File: tb/tb_template_mem_arbiter.sv
// Directed bench for template_mem_arbiter with a behavioural RAM and queue scoreboards
// for memory writes, read addresses and returned template words.
module tb_template_mem_arbiter;
    localparam int NT = 15, W = 50, DW = 16, AW = 10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_req = 0, wr_valid = 0, rd_req = 0, clear_all = 0;
    logic [3:0] wr_slot = '0, rd_slot = '0;
    logic [DW-1:0] wr_data = '0, mem_rdata = '0;
    logic wr_gnt, wr_ready, wr_done, rd_gnt, rd_data_valid, rd_last, rd_done;
    logic busy, err_slot, mem_en, mem_we;
    logic [DW-1:0] rd_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [NT-1:0] slot_valid;

    always #5 clk = ~clk;

    template_mem_arbiter #(.NUM_TEMPLATES(NT), .WORDS(W), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_req_i(wr_req), .wr_slot_i(wr_slot), .wr_gnt_o(wr_gnt),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready), .wr_done_o(wr_done),
        .rd_req_i(rd_req), .rd_slot_i(rd_slot), .rd_gnt_o(rd_gnt),
        .rd_data_valid_o(rd_data_valid), .rd_data_o(rd_data), .rd_last_o(rd_last),
        .rd_done_o(rd_done), .clear_all_i(clear_all), .slot_valid_o(slot_valid),
        .busy_o(busy), .err_slot_o(err_slot), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    int n_vec = 0, n_err = 0, cyc = 0;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit            wflag [0:(1<<AW)-1];
    logic [AW+DW-1:0] wq[$];
    logic [AW-1:0]    raq[$];
    logic [DW-1:0]    rq[$];
    logic [NT-1:0]    sv_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Unwritten locations read back as 0xDEAD so forced-zero reads are observable.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            wflag[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) mem_rdata <= wflag[mem_addr] ? ram[mem_addr] : 16'hDEAD;
        else                   mem_rdata <= '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (mem_en && mem_we) begin
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_addr_data", {mem_addr, mem_wdata}, wq.pop_front());
        end
        if (mem_en && !mem_we) begin
            if (raq.size() == 0) chk("rd_issue_unexpected", 1, 0);
            else chk("rd_addr", mem_addr, raq.pop_front());
        end
        if (rd_data_valid) begin
            if (rq.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", rd_data, rq.pop_front());
        end
    end

    task automatic write_burst(input int slot, input int first, input bit gaps,
                               input int abort_at, input bit clr_done, output int done_cyc);
        int tmo, last_acc;
        done_cyc = -1;
        wr_slot = slot[3:0];
        wr_req  = 1'b1;
        tmo = 0;
        @(negedge clk);
        while (!wr_gnt && tmo < 200) begin @(negedge clk); tmo++; end
        if (!wr_gnt) begin chk("wr_gnt_timeout", 0, 1); wr_req = 0; return; end
        chk("wr_grant_exclusive", rd_gnt, 0);
        sv_exp[slot] = 1'b0;
        chk("slot_clr_at_grant", slot_valid, sv_exp);
        @(posedge clk); #1;
        wr_req = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == abort_at) begin wr_valid = 0; return; end
            if (gaps && (i % 9 == 4)) begin wr_valid = 0; @(posedge clk); #1; end
            wr_valid = 1'b1;
            wr_data  = DW'(first + i);
            tmo = 0;
            @(negedge clk);
            while (!wr_ready && tmo < 10) begin @(negedge clk); tmo++; end
            if (!wr_ready) begin chk("wr_ready_timeout", 0, 1); wr_valid = 0; return; end
            wq.push_back({AW'(slot * W + i), DW'(first + i)});
            last_acc = cyc;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        if (clr_done) clear_all = 1'b1;
        @(negedge clk);
        done_cyc = cyc;
        chk("wr_done_latency", {wr_done, 8'(done_cyc - last_acc)}, {1'b1, 8'd1});
        chk("wr_gnt_in_done", {wr_gnt, wr_ready}, 2'b10);
        @(posedge clk); #1;
        clear_all = 1'b0;
        if (clr_done) sv_exp = '0;
        else          sv_exp[slot] = 1'b1;
        @(negedge clk);
        chk("wr_gnt_drop", {wr_gnt, wr_done}, 2'b00);
        chk("slot_valid_after_wr", slot_valid, sv_exp);
        chk("wr_queue_drained", wq.size(), 0);
    endtask

    task automatic read_burst(input int slot, input bit valid_exp, input int first, output int g);
        int tmo, first_v, last_c, done_c, idle_c, n_done;
        rd_slot = slot[3:0];
        rd_req  = 1'b1;
        tmo = 0;
        g = -1;
        @(negedge clk);
        while (!rd_gnt && tmo < 200) begin @(negedge clk); tmo++; end
        if (!rd_gnt) begin chk("rd_gnt_timeout", 0, 1); rd_req = 0; return; end
        g = cyc;
        rd_req = 1'b0;
        for (int i = 0; i < W; i++) begin
            raq.push_back(AW'(slot * W + i));
            rq.push_back(valid_exp ? DW'(first + i) : '0);
        end
        first_v = -1; last_c = -1; done_c = -1; idle_c = -1; n_done = 0;
        for (int k = 0; k < 58; k++) begin
            @(negedge clk);
            if (rd_data_valid && first_v < 0) first_v = cyc;
            if (rd_last) last_c = cyc;
            if (rd_done) begin done_c = cyc; n_done++; end
            if (!rd_gnt && idle_c < 0) idle_c = cyc;
        end
        chk("rd_first_valid", first_v - g, 3);
        chk("rd_last_time", last_c - g, W + 2);
        chk("rd_done_time", {8'(n_done), 8'(done_c - g)}, {8'd1, 8'(W + 2)});
        chk("rd_idle_time", idle_c - g, W + 3);
        chk("rd_queue_drained", rq.size() + raq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {wr_gnt, wr_ready, wr_done, rd_gnt, rd_data_valid, rd_last,
                             rd_done, busy, err_slot, mem_en, mem_we}, 0);
        chk({tag, "_slot_valid"}, slot_valid, 0);
        chk({tag, "_buses"}, {mem_addr, mem_wdata}, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, g, n_err_p, n_done_p, n_en;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Tie from reset: writer (slot 3, 1..50) first, then reader in the following IDLE cycle
        @(posedge clk); #1;
        rd_slot = 4'd3;
        rd_req  = 1'b1;
        write_burst(3, 1, 0, -1, 0, d);
        chk("slot_valid_0008", slot_valid, 15'h0008);
        read_burst(3, 1, 1, g);
        chk("rd_grant_after_wr_done", g - d, 2);

        // Second tie: last grant was the reader, so the writer wins again
        @(posedge clk); #1;
        rd_slot = 4'd4;
        rd_req  = 1'b1;
        write_burst(4, 16'h0100, 1, -1, 0, d);
        read_burst(4, 1, 16'h0100, g);
        chk("rd_grant_after_wr_done2", g - d, 2);

        // Out-of-range read slot
        @(posedge clk); #1;
        rd_slot = 4'd15;
        rd_req  = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_reject_pulse", {err_slot, rd_done, rd_gnt, busy, mem_en}, 5'b11000);
        n_err_p = 0; n_done_p = 0; n_en = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_err_p += int'(err_slot);
            n_done_p += int'(rd_done);
            n_en += int'(mem_en);
        end
        chk("rd_reject_single", {8'(n_err_p), 8'(n_done_p), 8'(n_en)}, 24'h0);

        // Out-of-range write slot
        @(posedge clk); #1;
        wr_slot = 4'd15;
        wr_req  = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_reject_pulse", {err_slot, wr_done, wr_gnt, mem_en}, 4'b1100);
        @(negedge clk);
        chk("wr_reject_single", {err_slot, wr_done}, 2'b00);

        // Never-written slot reads as zeros
        read_burst(7, 0, 0, g);

        // Reset in the middle of a write burst
        write_burst(2, 16'h0200, 0, 20, 0, d);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midburst_reset");
        wq.delete();
        sv_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // clear_all in the wr_done cycle beats the slot set
        @(posedge clk); #1;
        write_burst(5, 16'h0500, 0, -1, 0, d);
        chk("slot5_valid", slot_valid, 15'h0020);
        write_burst(2, 16'h0200, 0, -1, 1, d);
        chk("clear_beats_set", slot_valid, 15'h0000);
        read_burst(2, 0, 0, g);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
